// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the receive-side frame parser.
package rx_frame_pkg;

  // Parser states, in the order a well-formed frame walks through them.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_t;

  // Default start-of-frame marker.
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Running checksum is a byte-wide XOR.
  localparam int CHK_W = 8;

  // Increment an 8-bit error counter, sticking at all-ones.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_frame_parser_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles and flags the cycle in which
// the count would reach TIMEOUT. A clear in the same cycle always wins.
module rx_gap_timer #(
  parameter int TIMEOUT = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_reg;

  assign expire = enable && !clear && (cnt_reg == CW'(TIMEOUT - 1));

  // Count idle cycles; restart on clear or after firing.
  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_parser.sv
// Frame parser behind the UART receiver: SOF, LEN, payload, CHK.
// Good payloads are buffered and held for the host until acknowledged.
module rx_frame_parser
  import rx_frame_pkg::*;
#(
  parameter int         MAX_LEN  = 16,
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
  parameter int         TIMEOUT  = 2000,
  parameter int         ADDR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              frame_ready,
  output logic [7:0]        frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              frame_ack,
  output logic [7:0]        err_chk_cnt,
  output logic [7:0]        err_ovr_cnt,
  output logic              err_timeout
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t           state_reg, state_next;
  logic [7:0]       len_reg;
  logic [7:0]       idx_reg;
  logic [CHK_W-1:0] chk_reg;
  logic             frame_ready_reg;
  logic [7:0]       frame_len_reg;
  logic [7:0]       err_chk_cnt_reg;
  logic [7:0]       err_ovr_cnt_reg;
  logic             err_timeout_reg;
  logic             rd_valid_reg;
  logic [7:0]       ram_q_reg;
  logic [7:0]       mem [MAX_LEN];

  // Control strobes decoded by the FSM for the datapath.
  logic len_load, wr_en, chk_bad, ovr_drop, frame_accept, timeout_fire;
  logic in_frame, gap_expire;

  assign in_frame = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) ||
                    (state_reg == ST_CHK);

  rx_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_frame || rx_valid),
    .enable (in_frame && !rx_valid),
    .expire (gap_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next   = state_reg;
    len_load     = 1'b0;
    wr_en        = 1'b0;
    chk_bad      = 1'b0;
    ovr_drop     = 1'b0;
    frame_accept = 1'b0;
    timeout_fire = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (rx_valid && rx_data == SOF_BYTE) state_next = ST_LEN;
      end
      ST_LEN: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            chk_bad    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            len_load   = 1'b1;
            state_next = ST_PAYLOAD;
          end
        end else if (gap_expire) begin
          timeout_fire = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          wr_en = 1'b1;
          if (idx_reg == len_reg - 8'd1) state_next = ST_CHK;
        end else if (gap_expire) begin
          timeout_fire = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_reg) begin
            frame_accept = 1'b1;
            state_next   = ST_HOLD;
          end else begin
            chk_bad    = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (gap_expire) begin
          timeout_fire = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      ST_HOLD: begin
        ovr_drop = rx_valid;
        if (frame_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame bookkeeping, host-visible status and error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg         <= '0;
      idx_reg         <= '0;
      chk_reg         <= '0;
      frame_ready_reg <= 1'b0;
      frame_len_reg   <= '0;
      err_chk_cnt_reg <= '0;
      err_ovr_cnt_reg <= '0;
      err_timeout_reg <= 1'b0;
      rd_valid_reg    <= 1'b0;
    end else begin
      err_timeout_reg <= timeout_fire;
      if (len_load) begin
        len_reg <= rx_data;
        chk_reg <= rx_data;
        idx_reg <= '0;
      end
      if (wr_en) begin
        chk_reg <= chk_reg ^ rx_data;
        idx_reg <= idx_reg + 8'd1;
      end
      if (frame_accept) begin
        frame_ready_reg <= 1'b1;
        frame_len_reg   <= len_reg;
      end else if (state_reg == ST_HOLD && frame_ack) begin
        frame_ready_reg <= 1'b0;
      end
      if (chk_bad)  err_chk_cnt_reg <= sat_inc(err_chk_cnt_reg);
      if (ovr_drop) err_ovr_cnt_reg <= sat_inc(err_ovr_cnt_reg);
      // Reads outside the held frame return zero rather than stale buffer data.
      rd_valid_reg <= frame_ready_reg && (9'(rd_addr) < 9'(frame_len_reg));
    end
  end

  // Payload buffer: write during PAYLOAD, registered read for the host.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx_reg[ADDR_W-1:0]] <= rx_data;
    ram_q_reg <= mem[rd_addr];
  end

  assign rd_data     = rd_valid_reg ? ram_q_reg : 8'h00;
  assign frame_ready = frame_ready_reg;
  assign frame_len   = frame_len_reg;
  assign err_chk_cnt = err_chk_cnt_reg;
  assign err_ovr_cnt = err_ovr_cnt_reg;
  assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Randomized self-checking bench for rx_frame_parser with a frame-level model.
module tb_rx_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 24;
  localparam int         ADDR_W  = 4;
  localparam logic [7:0] SOF     = 8'hA5;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              frame_ready;
  logic [7:0]        frame_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_ack;
  logic [7:0]        err_chk_cnt;
  logic [7:0]        err_ovr_cnt;
  logic              err_timeout;

  always #5 clk = ~clk;

  rx_frame_parser #(
    .MAX_LEN  (MAX_LEN),
    .SOF_BYTE (SOF),
    .TIMEOUT  (TIMEOUT),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ack   (frame_ack),
    .err_chk_cnt (err_chk_cnt),
    .err_ovr_cnt (err_ovr_cnt),
    .err_timeout (err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int to_pulses = 0;

  // Reference model: event counts derived from the frame rules.
  int m_chk = 0;
  int m_ovr = 0;
  int m_to  = 0;

  // Each high cycle of err_timeout is counted once, mid-cycle.
  always @(negedge clk) if (err_timeout === 1'b1) to_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int rand_gap();
    int r = $urandom_range(0, 9);
    if (r < 6) return 0;
    if (r < 9) return $urandom_range(1, 4);
    return TIMEOUT - 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_seq(input logic [7:0] q[$], input bit rg);
    foreach (q[i]) send_byte(q[i], rg ? rand_gap() : 0);
  endtask

  // Build SOF, LEN, payload, CHK with the checksum over LEN and payload.
  function automatic void build_frame(input logic [7:0] pl[$], output logic [7:0] q[$]);
    logic [7:0] c = 8'(pl.size());
    q = {};
    q.push_back(SOF);
    q.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      q.push_back(pl[i]);
      c ^= pl[i];
    end
    q.push_back(c);
  endfunction

  function automatic void rand_payload(input int n, output logic [7:0] pl[$]);
    pl = {};
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endfunction

  task automatic check_counters(input string tag);
    check_eq({tag, ".chk_cnt"}, 32'(err_chk_cnt), 32'(sat(m_chk)));
    check_eq({tag, ".ovr_cnt"}, 32'(err_ovr_cnt), 32'(sat(m_ovr)));
    check_eq({tag, ".timeouts"}, 32'(to_pulses), 32'(m_to));
  endtask

  task automatic expect_no_frame(input string tag);
    check_eq({tag, ".ready"}, 32'(frame_ready), 32'd0);
    check_counters(tag);
  endtask

  // Verify a held frame, read it back, drop overrun bytes, then release it.
  task automatic hold_and_release(input logic [7:0] pl[$], input bit coincide,
                                  input int novr, input string tag);
    int n = pl.size();
    int a;
    check_eq({tag, ".ready"}, 32'(frame_ready), 32'd1);
    check_eq({tag, ".len"}, 32'(frame_len), 32'(n));
    for (int i = 0; i < n; i++) begin
      rd_addr = ADDR_W'(i);
      step();
      check_eq({tag, ".rd"}, 32'(rd_data), 32'(pl[i]));
    end
    if (n < MAX_LEN) begin
      rd_addr = ADDR_W'(n);
      step();
      check_eq({tag, ".rd_oor"}, 32'(rd_data), 32'd0);
    end
    for (int k = 0; k < novr; k++) begin
      send_byte(8'($urandom), $urandom_range(0, 2));
      m_ovr++;
    end
    if (novr > 0) begin
      a = $urandom_range(0, n - 1);
      rd_addr = ADDR_W'(a);
      step();
      check_eq({tag, ".rd_keep"}, 32'(rd_data), 32'(pl[a]));
    end
    rx_valid  = coincide;
    rx_data   = 8'($urandom);
    frame_ack = 1'b1;
    step();
    rx_valid  = 1'b0;
    frame_ack = 1'b0;
    if (coincide) m_ovr++;
    check_eq({tag, ".released"}, 32'(frame_ready), 32'd0);
    rd_addr = '0;
    step();
    check_eq({tag, ".rd_after_ack"}, 32'(rd_data), 32'd0);
    check_counters(tag);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] q[$];
    int kind, n, m;

    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rd_addr = '0; frame_ack = 1'b0;
    idle(3);
    rst = 1'b0;
    step();
    check_eq("reset.ready", 32'(frame_ready), 32'd0);
    check_eq("reset.len", 32'(frame_len), 32'd0);
    check_eq("reset.rd", 32'(rd_data), 32'd0);
    check_eq("reset.to", 32'(err_timeout), 32'd0);
    check_counters("reset");
    $display("txn reset: checked reset values");

    // Known-good frame A5 03 11 22 33 03.
    pl = {8'h11, 8'h22, 8'h33};
    q  = {SOF, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq(q, 1'b0);
    hold_and_release(pl, 1'b0, 0, "good_dir");
    $display("txn good_dir: len=3 accepted");

    // Bad checksum, then a good frame.
    q = {SOF, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_seq(q, 1'b0);
    m_chk++;
    expect_no_frame("badchk_dir");
    $display("txn badchk_dir: rejected");
    rand_payload(5, pl);
    build_frame(pl, q);
    send_seq(q, 1'b1);
    hold_and_release(pl, 1'b0, 0, "good_after_bad");
    $display("txn good_after_bad: len=5 accepted");

    // Zero and oversize lengths.
    q = {SOF, 8'h00};
    send_seq(q, 1'b0);
    q = {SOF, 8'h11};
    send_seq(q, 1'b0);
    m_chk += 2;
    expect_no_frame("badlen_dir");
    $display("txn badlen_dir: lengths 0 and 17 rejected");

    // Overrun: three drops while held, fourth coincides with the ack.
    rand_payload(4, pl);
    build_frame(pl, q);
    send_seq(q, 1'b0);
    hold_and_release(pl, 1'b1, 3, "overrun_dir");
    $display("txn overrun_dir: 4 bytes dropped");

    // Truncated frame times out, next frame is clean.
    q = {SOF, 8'h02, 8'h11};
    send_seq(q, 1'b0);
    idle(TIMEOUT + 3);
    m_to++;
    expect_no_frame("timeout_dir");
    pl = {8'h7E};
    q  = {SOF, 8'h01, 8'h7E, 8'h7F};
    send_seq(q, 1'b0);
    hold_and_release(pl, 1'b0, 0, "after_timeout");
    $display("txn timeout_dir: one pulse, following frame accepted");

    // Every gap one cycle short of the timeout still completes.
    rand_payload(3, pl);
    build_frame(pl, q);
    foreach (q[i]) send_byte(q[i], (i == 0) ? 0 : TIMEOUT - 1);
    hold_and_release(pl, 1'b0, 0, "gap_edge");
    $display("txn gap_edge: gaps of %0d idle cycles tolerated", TIMEOUT - 1);

    // Randomized mix of frame kinds.
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 4);
      n    = $urandom_range(1, MAX_LEN);
      rand_payload(n, pl);
      build_frame(pl, q);
      case (kind)
        0: begin
          send_seq(q, 1'b1);
          hold_and_release(pl, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rnd_good");
          $display("txn %0d good len=%0d", t, n);
        end
        1: begin
          q[q.size() - 1] = q[q.size() - 1] ^ 8'($urandom_range(1, 255));
          send_seq(q, 1'b1);
          m_chk++;
          expect_no_frame("rnd_badchk");
          $display("txn %0d badchk len=%0d", t, n);
        end
        2: begin
          q = {SOF, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255))};
          send_seq(q, 1'b1);
          m_chk++;
          expect_no_frame("rnd_badlen");
          $display("txn %0d badlen=%0d", t, q[1]);
        end
        3: begin
          m = $urandom_range(1, n + 2);
          for (int i = 0; i < m; i++) send_byte(q[i], rand_gap());
          idle(TIMEOUT + 3);
          m_to++;
          expect_no_frame("rnd_timeout");
          $display("txn %0d timeout after %0d of %0d bytes", t, m, n + 3);
        end
        default: begin
          m = $urandom_range(1, 6);
          for (int i = 0; i < m; i++) send_byte(8'($urandom_range(0, 8'hA4)), rand_gap());
          expect_no_frame("rnd_junk");
          $display("txn %0d junk x%0d ignored", t, m);
        end
      endcase
    end

    // Saturation of both counters.
    q = {SOF, 8'h00};
    for (int i = 0; i < 260; i++) send_seq(q, 1'b0);
    m_chk += 260;
    expect_no_frame("sat_chk");
    $display("txn sat_chk: err_chk_cnt=%0d", err_chk_cnt);
    rand_payload(2, pl);
    build_frame(pl, q);
    send_seq(q, 1'b0);
    hold_and_release(pl, 1'b0, 260, "sat_ovr");
    $display("txn sat_ovr: err_ovr_cnt=%0d", err_ovr_cnt);

    // Reset mid-payload abandons the frame and clears counters.
    q = {SOF, 8'h05, 8'h11, 8'h22};
    send_seq(q, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_chk = 0;
    m_ovr = 0;
    check_eq("midrst.to", 32'(err_timeout), 32'd0);
    check_eq("midrst.rd", 32'(rd_data), 32'd0);
    expect_no_frame("midrst");
    rand_payload(6, pl);
    build_frame(pl, q);
    send_seq(q, 1'b1);
    hold_and_release(pl, 1'b0, 0, "after_rst");
    idle(TIMEOUT + 3);
    check_counters("final");
    $display("txn midrst: frame after reset accepted");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
